// File: rtl/ucode_pkg.sv
// Shared types and constants for the ucode stack memory response path.
package ucode_pkg;

  localparam int unsigned UcrDataW = 32;
  localparam int unsigned UcrTmoW  = 8;

  localparam logic [UcrTmoW-1:0] UCR_TMO_MAX = 8'd255;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCapt = 2'd1,
    StBusy = 2'd2,
    StPend = 2'd3
  } ucr_state_e;

  typedef struct packed {
    logic                wr;
    logic [UcrDataW-1:0] addr;
    logic [UcrDataW-1:0] wdata;
  } ucr_req_t;

endpackage

// File: rtl/ucode_resp_tmo.sv
// Saturating timeout counter for an outstanding memory handshake.
module ucode_resp_tmo
  import ucode_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic hit
);

  logic [UcrTmoW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != UCR_TMO_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == UCR_TMO_MAX);

endmodule

// File: rtl/ucode_mem_resp.sv
// Bridges ucode stack read/write requests onto the DCU request/ack handshake,
// with abort, timeout kill and a one-entry parked write for combined rd+wt.
module ucode_mem_resp
  import ucode_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                u_f01_wt_stk,
  input  logic                u_f02_rd_stk,
  input  logic                u_abt_rdwt,
  input  logic                u_abt_cur,
  input  logic [UcrDataW-1:0] u_addr,
  input  logic [UcrDataW-1:0] u_wdata,
  input  logic                dcu_ack,
  input  logic                dcu_err,
  input  logic [UcrDataW-1:0] dcu_rdata,
  output logic                dcu_req,
  output logic                dcu_wr,
  output logic [UcrDataW-1:0] dcu_addr,
  output logic [UcrDataW-1:0] dcu_wdata,
  output logic                ie_stall_ucode,
  output logic                ie_kill_ucode,
  output logic [UcrDataW-1:0] u_rdata,
  output logic                u_rdata_vld
);

  ucr_state_e          state_q, state_d;
  ucr_req_t            cur_q, cur_d;
  ucr_req_t            pend_q, pend_d;
  logic                pend_vld_q, pend_vld_d;
  logic [UcrDataW-1:0] rdata_q, rdata_d;
  logic                rdata_vld_q, rdata_vld_d;
  logic                kill_q, kill_d;
  logic                tmo_en, tmo_hit;
  logic                busy;

  assign busy = (state_q == StBusy);

  // Held cleared outside BUSY so every entry (from CAPT or PEND) starts at zero.
  ucode_resp_tmo u_tmo (
    .clk   (clk),
    .reset (reset),
    .clr   (!busy),
    .en    (tmo_en),
    .hit   (tmo_hit)
  );

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    rdata_d     = rdata_q;
    rdata_vld_d = 1'b0;
    kill_d      = 1'b0;
    tmo_en      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (u_f02_rd_stk || u_f01_wt_stk) begin
          // A combined request issues the read first and parks the write.
          cur_d.wr     = !u_f02_rd_stk;
          cur_d.addr   = u_addr;
          cur_d.wdata  = u_wdata;
          pend_vld_d   = u_f02_rd_stk && u_f01_wt_stk;
          pend_d.wr    = 1'b1;
          pend_d.addr  = u_addr;
          pend_d.wdata = u_wdata;
          state_d      = StCapt;
        end
      end

      StCapt: begin
        if (u_abt_rdwt || u_abt_cur) begin
          pend_vld_d = 1'b0;
          state_d    = StIdle;
        end else begin
          state_d = StBusy;
        end
      end

      StBusy: begin
        if (dcu_ack) begin
          if (dcu_err) begin
            kill_d     = 1'b1;
            pend_vld_d = 1'b0;
            state_d    = StIdle;
          end else begin
            if (!cur_q.wr) begin
              rdata_d     = dcu_rdata;
              rdata_vld_d = 1'b1;
            end
            state_d = pend_vld_q ? StPend : StIdle;
          end
        end else if (tmo_hit) begin
          // An ack in the hit cycle wins above; only a silent DCU is killed.
          kill_d     = 1'b1;
          pend_vld_d = 1'b0;
          state_d    = StIdle;
        end else begin
          tmo_en = 1'b1;
        end
      end

      StPend: begin
        cur_d      = pend_q;
        pend_vld_d = 1'b0;
        state_d    = StBusy;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      rdata_q     <= '0;
      rdata_vld_q <= 1'b0;
      kill_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      rdata_q     <= rdata_d;
      rdata_vld_q <= rdata_vld_d;
      kill_q      <= kill_d;
    end
  end

  assign dcu_req        = busy;
  assign dcu_wr         = busy && cur_q.wr;
  assign dcu_addr       = busy ? cur_q.addr  : '0;
  assign dcu_wdata      = busy ? cur_q.wdata : '0;
  assign ie_stall_ucode = (state_q != StIdle);
  assign ie_kill_ucode  = kill_q;
  assign u_rdata        = rdata_q;
  assign u_rdata_vld    = rdata_vld_q;

endmodule
